// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired Moore control unit for a small load/store processor. It walks the
// fetch sequence (T0..T2) and then the execute steps of the decoded
// instruction class (R-type, addi, ld, st). It pauses at instruction
// boundaries on request and stops permanently on halt.
//
// Ports
//   clock     in   rising-edge system clock
//   reset     in   synchronous active-high reset
//   opcode    in   [4:0] instruction opcode (IR[31:27])
//   mem_done  in   memory completion strobe, looked at in wait states only
//   stop      in   pause request, honoured at the next instruction boundary
//   PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
//   Zlowout, Cout                       out  datapath strobes
//   Gra, Grb, Grc, Rin, Rout, BAout     out  register select/encode controls
//   alu_op    out  [4:0] ALU function code
//   run       out  high while executing (not paused, not halted)
// -----------------------------------------------------------------------------
module control_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic [4:0] opcode,
   input  logic       mem_done,
   input  logic       stop,
   output logic       PCout,
   output logic       PCin,
   output logic       IncPC,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       Read,
   output logic       Write,
   output logic       IRin,
   output logic       Yin,
   output logic       Zin,
   output logic       Zlowout,
   output logic       Cout,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       BAout,
   output logic [4:0] alu_op,
   output logic       run
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // Function code used for every address/immediate/PC addition.
   localparam logic [4:0] ALU_ADD = 5'b00011;

   typedef enum logic [4:0] {
      S_IDLE,
      S_T0, S_T1, S_T2,
      S_R3, S_R4, S_R5,
      S_I3, S_I4, S_I5,
      S_L3, S_L4, S_L5, S_L6, S_L7,
      S_S3, S_S4, S_S5, S_S6, S_S7,
      S_HALT
   } state_t;

   typedef struct packed {
      logic       pc_out;
      logic       pc_in;
      logic       inc_pc;
      logic       mar_in;
      logic       mdr_in;
      logic       mdr_out;
      logic       read;
      logic       write;
      logic       ir_in;
      logic       y_in;
      logic       z_in;
      logic       zlow_out;
      logic       c_out;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic [4:0] alu_op;
      logic       run;
   } ctrl_t;

   state_t     state_reg;
   state_t     state_next;
   state_t     boundary_state;
   logic [4:0] op_reg;
   logic [4:0] op_next;
   ctrl_t      ctrl_reg;
   ctrl_t      ctrl_out;

   // Control word for a given state. op is only consulted in R4, where the
   // ALU performs the instruction's own operation.
   function automatic ctrl_t decode(input state_t s, input logic [4:0] op);
      ctrl_t c;
      c     = '0;
      c.run = (s != S_IDLE) && (s != S_HALT);
      case (s)
         S_T0: begin
            c.pc_out = 1'b1;
            c.mar_in = 1'b1;
            c.inc_pc = 1'b1;
            c.z_in   = 1'b1;
            c.alu_op = ALU_ADD;
         end
         S_T1: begin
            c.zlow_out = 1'b1;
            c.pc_in    = 1'b1;
            c.read     = 1'b1;
            c.mdr_in   = 1'b1;
         end
         S_T2: begin
            c.mdr_out = 1'b1;
            c.ir_in   = 1'b1;
         end
         S_R3, S_I3: begin
            c.grb   = 1'b1;
            c.r_out = 1'b1;
            c.y_in  = 1'b1;
         end
         S_R4: begin
            c.grc    = 1'b1;
            c.r_out  = 1'b1;
            c.z_in   = 1'b1;
            c.alu_op = op;
         end
         S_I4, S_L4, S_S4: begin
            c.c_out  = 1'b1;
            c.z_in   = 1'b1;
            c.alu_op = ALU_ADD;
         end
         S_R5, S_I5: begin
            c.zlow_out = 1'b1;
            c.gra      = 1'b1;
            c.r_in     = 1'b1;
         end
         S_L3, S_S3: begin
            c.grb    = 1'b1;
            c.ba_out = 1'b1;
            c.y_in   = 1'b1;
         end
         S_L5, S_S5: begin
            c.zlow_out = 1'b1;
            c.mar_in   = 1'b1;
         end
         S_L6: begin
            c.read   = 1'b1;
            c.mdr_in = 1'b1;
         end
         S_L7: begin
            c.mdr_out = 1'b1;
            c.gra     = 1'b1;
            c.r_in    = 1'b1;
         end
         S_S6: begin
            c.gra    = 1'b1;
            c.r_out  = 1'b1;
            c.mdr_in = 1'b1;
         end
         S_S7: begin
            c.write = 1'b1;
         end
         default: ;
      endcase
      return c;
   endfunction

   // Where the sequencer goes when an instruction finishes: a pending stop
   // request parks it in IDLE instead of starting the next fetch.
   assign boundary_state = stop ? S_IDLE : S_T0;

   // The opcode is captured on the dispatch edge so R4 uses the opcode of the
   // instruction being executed even if the input moves later.
   assign op_next = (state_reg == S_T2) ? opcode : op_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (!stop) state_next = S_T0;
         S_T0:   state_next = S_T1;
         S_T1:   if (mem_done) state_next = S_T2;
         S_T2: begin
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR: state_next = S_R3;
               OP_ADDI:                       state_next = S_I3;
               OP_LD:                         state_next = S_L3;
               OP_ST:                         state_next = S_S3;
               OP_HALT:                       state_next = S_HALT;
               default:                       state_next = boundary_state;
            endcase
         end
         S_R3:   state_next = S_R4;
         S_R4:   state_next = S_R5;
         S_R5:   state_next = boundary_state;
         S_I3:   state_next = S_I4;
         S_I4:   state_next = S_I5;
         S_I5:   state_next = boundary_state;
         S_L3:   state_next = S_L4;
         S_L4:   state_next = S_L5;
         S_L5:   state_next = S_L6;
         S_L6:   if (mem_done) state_next = S_L7;
         S_L7:   state_next = boundary_state;
         S_S3:   state_next = S_S4;
         S_S4:   state_next = S_S5;
         S_S5:   state_next = S_S6;
         S_S6:   state_next = S_S7;
         S_S7:   if (mem_done) state_next = boundary_state;
         S_HALT: state_next = S_HALT;
         default: state_next = S_T0;
      endcase
   end

   // The control word is registered from the next state, so the strobes of
   // each state appear together with the state itself and never glitch.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= S_T0;
         op_reg    <= '0;
         ctrl_reg  <= decode(S_T0, 5'b00000);
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         ctrl_reg  <= decode(state_next, op_next);
      end
   end

   // Outputs must read zero for as long as reset is high, including the cycle
   // in which it is first raised, so the registered word is gated by reset.
   assign ctrl_out = reset ? '0 : ctrl_reg;

   assign PCout   = ctrl_out.pc_out;
   assign PCin    = ctrl_out.pc_in;
   assign IncPC   = ctrl_out.inc_pc;
   assign MARin   = ctrl_out.mar_in;
   assign MDRin   = ctrl_out.mdr_in;
   assign MDRout  = ctrl_out.mdr_out;
   assign Read    = ctrl_out.read;
   assign Write   = ctrl_out.write;
   assign IRin    = ctrl_out.ir_in;
   assign Yin     = ctrl_out.y_in;
   assign Zin     = ctrl_out.z_in;
   assign Zlowout = ctrl_out.zlow_out;
   assign Cout    = ctrl_out.c_out;
   assign Gra     = ctrl_out.gra;
   assign Grb     = ctrl_out.grb;
   assign Grc     = ctrl_out.grc;
   assign Rin     = ctrl_out.r_in;
   assign Rout    = ctrl_out.r_out;
   assign BAout   = ctrl_out.ba_out;
   assign alu_op  = ctrl_out.alu_op;
   assign run     = ctrl_out.run;

endmodule
